// File: rtl/ff_inv_secp256k1.sv
// rtl/ff_inv_secp256k1.sv - secp256k1 field inverter (Fermat, square-and-multiply)
// Also holds ff_mul, the single-shot modular multiplier the inverter drives.

module ff_mul (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] rx_a,
  input  logic [255:0] rx_b,
  output logic         tx_done,
  output logic [255:0] tx_c
);
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  // 2^256 mod p = 2^32 + 977, used to fold the high half back in twice.
  localparam logic [32:0] FOLD = 33'h1_000003D1;

  logic [511:0] prod;
  logic [289:0] t;
  logic [256:0] u;
  logic [256:0] diff;
  logic [255:0] red;

  always_comb begin
    prod = {256'b0, rx_a} * {256'b0, rx_b};
    t    = {34'b0, prod[255:0]} + 290'(prod[511:256]) * 290'(FOLD);
    u    = {1'b0, t[255:0]} + 257'(t[289:256]) * 257'(FOLD);
    diff = u - {1'b0, P};
    red  = diff[256] ? u[255:0] : diff[255:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done <= 1'b0;
      tx_c    <= 256'b0;
    end else if (!tx_done) begin
      tx_c    <= red;
      tx_done <= 1'b1;
    end
  end
endmodule

module ff_inv_secp256k1 (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] rx_a,
  output logic         tx_done,
  output logic [255:0] tx_a
);
  localparam logic [255:0] E = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

  typedef enum logic [2:0] {SQ_GO, SQ_WAIT, ML_GO, ML_WAIT, ADV, FIN} state_t;

  state_t       state;
  state_t       state_nx;
  logic [255:0] r;
  logic [255:0] sel_a;
  logic [255:0] sel_b;
  logic [7:0]   i;
  logic         mul_rst;
  logic         mul_reset;
  logic         mul_done;
  logic [255:0] mul_c;

  assign mul_reset = reset | mul_rst;

  ff_mul u_mul (
    .clk     (clk),
    .reset   (mul_reset),
    .rx_a    (sel_a),
    .rx_b    (sel_b),
    .tx_done (mul_done),
    .tx_c    (mul_c)
  );

  always_comb begin
    state_nx = state;
    case (state)
      SQ_GO:   state_nx = SQ_WAIT;
      SQ_WAIT: if (mul_done) state_nx = E[i] ? ML_GO : ADV;
      ML_GO:   state_nx = ML_WAIT;
      ML_WAIT: if (mul_done) state_nx = ADV;
      ADV:     state_nx = (i == 8'd0) ? FIN : SQ_GO;
      FIN:     state_nx = FIN;
      default: state_nx = SQ_GO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SQ_GO;
      r       <= 256'd1;
      i       <= 8'd255;
      mul_rst <= 1'b1;
      sel_a   <= 256'b0;
      sel_b   <= 256'b0;
      tx_done <= 1'b0;
      tx_a    <= 256'b0;
    end else begin
      state <= state_nx;
      case (state)
        SQ_GO: begin
          sel_a   <= r;
          sel_b   <= r;
          mul_rst <= 1'b0;
        end
        // mul_rst rises here so the multiplier's done flag is cleared by the next GO.
        SQ_WAIT, ML_WAIT: begin
          if (mul_done) begin
            r       <= mul_c;
            mul_rst <= 1'b1;
          end
        end
        ML_GO: begin
          sel_a   <= r;
          sel_b   <= rx_a;
          mul_rst <= 1'b0;
        end
        ADV: begin
          if (i != 8'd0) i <= i - 8'd1;
        end
        FIN: begin
          tx_a    <= r;
          tx_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
